huffman_encoder: RTL and testbench
==================================

// Module: huffman_encoder
// PURPOSE
//  Bitstream packer; pair of the HuffmanDecoder. Accepts 4-bit symbols over a valid/ready handshake.
//  Maps each symbol to its prefix code (length 1..6) and packs the codes MSB-first into 10-bit words.
//  The words are the exact stream the HuffmanDecoder consumes through its 10-bit encodedData window.
//  Sits between the symbol source and the channel or storage feeding the decoder.
// PARAMETERS
//  WORD_W  10  output word width; fixed to the decoder window, any other value is unsupported
//  CNT_W   16  width of statistics counters (used only with HENC_STATS_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  sym_in     in   4       symbol to encode
//  sym_valid  in   1       sym_in valid
//  sym_ready  out  1       encoder accepts sym_in this cycle
//  flush      in   1       request to emit the partial word; level, sampled when accepted
//  flush_done out  1       1-cycle pulse when the flush has completed
//  enc_word   out  WORD_W  packed code bits, first code bit in bit 9
//  enc_bits   out  4       number of valid MSBs in enc_word: 10 for full words, 1..9 for a flush word
//  enc_valid  out  1       enc_word/enc_bits valid; held stable until enc_ready
//  enc_ready  in   1       downstream accepts the word
//  err_sym    out  1       1-cycle pulse: an unmapped symbol (11 or 13) was accepted and dropped
// BEHAVIOUR
//  Code table {sym:code}:
//   0:1
//   9:0111  2:0101  1:0100  6:0011  5:0010  10:0000
//   7:01101
//   3:011000  4:011001  8:000110  12:000111  14:000100  15:000101
//  Symbols 11 and 13 are unmapped: they are accepted, contribute no bits, and pulse err_sym next cycle.
//  Datapath: 16-bit left-aligned accumulator acc and 5-bit fill count (0..15).
//  States:
//   FILL:  sym_ready = (fill<10). On accept: acc[15-fill -: len] <= code; fill += len.
//          If fill>=10 at the clock edge: enc_word<=acc[15:6]; enc_bits<=10; acc<=acc<<10; fill-=10; enc_valid<=1; ->OUT.
//   OUT:   sym_ready=0; when enc_valid&&enc_ready: enc_valid<=0; ->FILL, or ->FLUSH if flush_pend.
//   FLUSH: if fill>=10: emit a full word first and ->OUT with flush_pend still set.
//          elif fill>0: enc_word<=acc[15:6] (zero-padded LSBs); enc_bits<=fill; fill<=0; acc<=0; clear flush_pend;
//            ->OUT; flush_done pulses on the handshake of that word.
//          else: flush_done pulse; ->FILL.
//  Flush acceptance: flush is sampled in FILL and sets flush_pend.
//   If a symbol is accepted in the same cycle, the symbol is appended first.
//   A flush raised in OUT is latched into flush_pend.
//  Latency: the symbol that completes a word is accepted on edge N; enc_valid rises on edge N+1.
//  Throughput: at most one word per 2 cycles; a 6-bit code never overflows acc (max fill 9+6=15).
//  Backpressure: enc_valid, enc_word and enc_bits are stable while enc_ready=0; no symbol is accepted in OUT.
//  Reset values:
//   sym_ready=0 (1 from the first cycle after reset); enc_valid=0; enc_word=0; enc_bits=0;
//   flush_done=0; err_sym=0; acc=0; fill=0; flush_pend=0; state=FILL.
//  Reset mid-word discards buffered bits; no partial word is emitted.
// CONFIGURATION
//  HENC_STATS_EN defined:
//   Adds outputs sym_count[CNT_W-1:0] (mapped symbols accepted) and bit_count[CNT_W-1:0] (code bits appended).
//   Both are reset to 0, saturate at all-ones, and increment in the accept cycle.
//  HENC_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package henc_pkg:
//   WORD_W, MAX_CODE_LEN=6, ACC_W=16, state enum {FILL,OUT,FLUSH},
//   function code_of(sym) returning {len[2:0], code[5:0] right-aligned}; the table is shared with decoder test benches.
//  Sub-module huff_code_lut: combinational sym_in -> code, len, illegal. All sequential logic stays in huffman_encoder.
// TESTING
//  T1: ten symbol 0 with enc_ready=1 -> one word 10'h3FF, enc_bits=10, fill=0 afterwards.
//  T2: symbols 9,2,0,0 -> enc_word=10'h1D7 (0111010111), enc_bits=10.
//  T3: symbol 7 then flush -> enc_word=10'h1A0, enc_bits=5, flush_done after handshake.
//      Flush with fill=0 -> flush_done only, no word.
//  T4: symbol 11 -> err_sym pulse, fill unchanged. Symbol 13 -> same.
//      Under HENC_STATS_EN, sym_count is unchanged.
//  T5: hold enc_ready=0 for 5 cycles with a word pending -> enc_word stable, sym_ready=0; resumes on release.
//  T6: assert rst mid-stream with fill=7 -> all outputs at reset values, next word starts from the new symbols.
//      Encoder->HuffmanDecoder loopback of 200 random mapped symbols must round-trip.

Source files
------------

// File: rtl/henc_pkg.sv
// Shared definitions for the Huffman bitstream packer: widths, FSM states and
// the symbol->prefix-code table (also consumed by decoder-side benches).
package henc_pkg;

  localparam int WORD_W       = 10;
  localparam int MAX_CODE_LEN = 6;
  localparam int ACC_W        = 16;
  localparam int FILL_W       = 5;

  typedef enum logic [1:0] {FILL, OUT, FLUSH} henc_state_e;

  // len == 0 marks an unmapped symbol
  typedef struct packed {
    logic [2:0]              len;
    logic [MAX_CODE_LEN-1:0] code;   // right-aligned
  } henc_code_t;

  function automatic henc_code_t code_of(input logic [3:0] sym);
    henc_code_t c;
    case (sym)
      4'd0:    c = {3'd1, 6'b000001};
      4'd1:    c = {3'd4, 6'b000100};
      4'd2:    c = {3'd4, 6'b000101};
      4'd3:    c = {3'd6, 6'b011000};
      4'd4:    c = {3'd6, 6'b011001};
      4'd5:    c = {3'd4, 6'b000010};
      4'd6:    c = {3'd4, 6'b000011};
      4'd7:    c = {3'd5, 6'b001101};
      4'd8:    c = {3'd6, 6'b000110};
      4'd9:    c = {3'd4, 6'b000111};
      4'd10:   c = {3'd4, 6'b000000};
      4'd12:   c = {3'd6, 6'b000111};
      4'd14:   c = {3'd6, 6'b000100};
      4'd15:   c = {3'd6, 6'b000101};
      default: c = {3'd0, 6'b000000};   // 11, 13
    endcase
    return c;
  endfunction

endpackage

// File: rtl/huff_code_lut.sv
// Combinational symbol -> prefix code lookup.
module huff_code_lut
  import henc_pkg::*;
(
  input  logic [3:0]              sym_i,
  output logic [MAX_CODE_LEN-1:0] code_o,
  output logic [2:0]              len_o,
  output logic                    illegal_o
);

  henc_code_t c;

  assign c         = code_of(sym_i);
  assign code_o    = c.code;
  assign len_o     = c.len;
  assign illegal_o = (c.len == 3'd0);

endmodule

// File: rtl/huffman_encoder.sv
// Huffman bitstream packer: symbols in over valid/ready, prefix codes packed
// MSB-first into 10-bit words through a 16-bit left-aligned accumulator.
// Optional HENC_STATS_EN adds saturating symbol / code-bit counters.
module huffman_encoder #(
  parameter int WORD_W = 10
`ifdef HENC_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic [WORD_W-1:0] enc_word,
  output logic [3:0]        enc_bits,
  output logic              enc_valid,
  input  logic              enc_ready,
`ifdef HENC_STATS_EN
  output logic [CNT_W-1:0]  sym_count,
  output logic [CNT_W-1:0]  bit_count,
`endif
  output logic              err_sym
);
  import henc_pkg::*;

  localparam logic [FILL_W-1:0] FULL = FILL_W'(WORD_W);

  henc_state_e             state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d, ins;
  logic [FILL_W-1:0]       fill_q, fill_d, shamt;
  logic                    pend_q, pend_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [3:0]              bits_q, bits_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    live_q;
  logic                    full, accept;
  logic [MAX_CODE_LEN-1:0] lut_code;
  logic [2:0]              lut_len;
  logic                    lut_illegal;

  huff_code_lut u_lut (
    .sym_i     (sym_in),
    .code_o    (lut_code),
    .len_o     (lut_len),
    .illegal_o (lut_illegal)
  );

  assign full   = (fill_q >= FULL);
  assign accept = sym_valid && sym_ready;
  // Code lands at acc[15-fill -: len]: shift the right-aligned code up to there
  assign shamt  = FILL_W'(ACC_W) - fill_q - {2'b00, lut_len};
  assign ins    = ACC_W'(lut_code) << shamt;

  // Gives sym_ready a reset value of 0 even though the FSM idles in FILL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (full) state_d = OUT;
               else if (flush) state_d = FLUSH;
      OUT:     if (valid_q && enc_ready) state_d = (pend_q || flush) ? FLUSH : FILL;
      FLUSH:   state_d = (fill_q != '0) ? OUT : FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    sym_ready = live_q && (state_q == FILL) && !full;
    acc_d   = acc_q;
    fill_d  = fill_q;
    pend_d  = pend_q;
    word_d  = word_q;
    bits_d  = bits_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (flush) pend_d = 1'b1;
        if (full) begin
          word_d  = acc_q[ACC_W-1 -: WORD_W];
          bits_d  = 4'(WORD_W);
          acc_d   = acc_q << WORD_W;
          fill_d  = fill_q - FULL;
          valid_d = 1'b1;
        end else if (accept) begin
          if (lut_illegal) err_d = 1'b1;
          else begin
            acc_d  = acc_q | ins;
            fill_d = fill_q + {2'b00, lut_len};
          end
        end
      end
      OUT: begin
        if (flush) pend_d = 1'b1;
        if (valid_q && enc_ready) begin
          valid_d = 1'b0;
          // Only a flush word is ever shorter than a full word
          if (bits_q != 4'(WORD_W)) done_d = 1'b1;
        end
      end
      FLUSH: begin
        if (full) begin
          word_d  = acc_q[ACC_W-1 -: WORD_W];
          bits_d  = 4'(WORD_W);
          acc_d   = acc_q << WORD_W;
          fill_d  = fill_q - FULL;
          valid_d = 1'b1;
        end else if (fill_q != '0) begin
          word_d  = acc_q[ACC_W-1 -: WORD_W];
          bits_d  = fill_q[3:0];
          acc_d   = '0;
          fill_d  = '0;
          pend_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          pend_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      word_q  <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign enc_word   = word_q;
  assign enc_bits   = bits_q;
  assign enc_valid  = valid_q;
  assign flush_done = done_q;
  assign err_sym    = err_q;

`ifdef HENC_STATS_EN
  logic [CNT_W-1:0] sym_cnt_q, bit_cnt_q;
  logic [CNT_W:0]   bit_sum;

  assign bit_sum = {1'b0, bit_cnt_q} + (CNT_W+1)'(lut_len);

  // Saturating counters, advanced in the accept cycle of each mapped symbol
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (accept && !lut_illegal) begin
      if (sym_cnt_q != '1) sym_cnt_q <= sym_cnt_q + CNT_W'(1);
      bit_cnt_q <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
  end

  assign sym_count = sym_cnt_q;
  assign bit_count = bit_cnt_q;
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: directed steps plus a randomized
// run, checked against a bit-queue model and a software prefix decoder.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sym_in;
  logic       sym_valid, sym_ready, flush, flush_done;
  logic [9:0] enc_word;
  logic [3:0] enc_bits;
  logic       enc_valid, enc_ready, err_sym;
`ifdef HENC_STATS_EN
  logic [15:0] sym_count, bit_count;
`endif

  int nvec = 0;
  int nmis = 0;
  // Code table: length 0 = unmapped
  int tlen  [16] = '{1, 4, 4, 6, 6, 4, 4, 5, 6, 4, 4, 0, 6, 0, 6, 6};
  int tcode [16] = '{'b1, 'b0100, 'b0101, 'b011000, 'b011001, 'b0010, 'b0011, 'b01101,
                     'b000110, 'b0111, 'b0000, 0, 'b000111, 0, 'b000100, 'b000101};
  bit bq[$];       // bits accepted but not yet emitted
  bit stream[$];   // bits actually emitted (valid MSBs only)
  int sent[$];
  int dec[$];
  int nmapped = 0;
  int nbits   = 0;

  huffman_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .flush     (flush),
    .flush_done(flush_done),
    .enc_word  (enc_word),
    .enc_bits  (enc_bits),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready),
`ifdef HENC_STATS_EN
    .sym_count (sym_count),
    .bit_count (bit_count),
`endif
    .err_sym   (err_sym)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int peek_n();
    return (bq.size() >= 10) ? 10 : bq.size();
  endfunction

  function automatic logic [9:0] peek_word();
    logic [9:0] w;
    w = '0;
    for (int i = 0; i < peek_n(); i++) w[9-i] = bq[i];
    return w;
  endfunction

  // Called at a negedge: score handshakes about to happen, then advance one cycle
  task automatic cyc();
    int n;
    if (enc_valid === 1'b1 && enc_ready === 1'b1) begin
      n = peek_n();
      chk("word", enc_word, peek_word());
      chk("bits", enc_bits, n);
      for (int i = 0; i < n; i++) void'(bq.pop_front());
      for (int i = 0; i < enc_bits && i < 10; i++) stream.push_back(enc_word[9-i]);
    end
    if (sym_valid === 1'b1 && sym_ready === 1'b1 && tlen[sym_in] > 0) begin
      for (int i = tlen[sym_in] - 1; i >= 0; i--) bq.push_back(tcode[sym_in][i]);
      sent.push_back(int'(sym_in));
      nmapped++;
      nbits += tlen[sym_in];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int s);
    int t;
    t = 0;
    sym_in = 4'(s);
    sym_valid = 1'b1;
    while (sym_ready !== 1'b1 && t < 50) begin cyc(); t++; end
    chk("send ready", sym_ready, 1);
    cyc();
    sym_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (enc_valid !== 1'b1 && t < 40) begin cyc(); t++; end
    chk(tag, enc_valid, 1);
  endtask

  initial begin
    int t, s, idx, v;
    bit found, sawdone, sawword;
    rst = 1'b0; sym_in = '0; sym_valid = 1'b0; flush = 1'b0; enc_ready = 1'b1;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst sym_ready", sym_ready, 0);
    chk("rst enc_valid", enc_valid, 0);
    chk("rst enc_word", enc_word, 0);
    chk("rst enc_bits", enc_bits, 0);
    chk("rst flush_done", flush_done, 0);
    chk("rst err_sym", err_sym, 0);
    rst = 1'b1;
    cyc();
    chk("post-rst sym_ready", sym_ready, 1);

    // T1: ten zeros -> all-ones word
    for (int i = 0; i < 10; i++) send(0);
    wait_valid("T1 valid");
    chk("T1 word", enc_word, 10'h3FF);
    chk("T1 bits", enc_bits, 10);
    cyc();
    chk("T1 fill", dut.fill_q, 0);

    // T2: 9,2,0,0
    send(9); send(2); send(0); send(0);
    wait_valid("T2 valid");
    chk("T2 word", enc_word, 10'h1D7);
    chk("T2 bits", enc_bits, 10);
    cyc();

    // T3: symbol 7 then flush -> padded partial word, done after handshake
    send(7);
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_valid("T3 valid");
    chk("T3 word", enc_word, 10'h1A0);
    chk("T3 bits", enc_bits, 5);
    cyc();
    chk("T3 done pulse", flush_done, 1);
    cyc();
    chk("T3 done low", flush_done, 0);
    // Empty flush: done only
    flush = 1'b1; cyc(); flush = 1'b0;
    sawdone = 0; sawword = 0;
    for (int i = 0; i < 6; i++) begin
      if (flush_done === 1'b1) sawdone = 1;
      if (enc_valid === 1'b1) sawword = 1;
      cyc();
    end
    chk("T3 empty done", sawdone, 1);
    chk("T3 empty noword", sawword, 0);

    // T4: unmapped symbols
    send(0);
    send(11);
    chk("T4 err 11", err_sym, 1);
    chk("T4 fill 11", dut.fill_q, 1);
    cyc();
    chk("T4 err low", err_sym, 0);
    send(13);
    chk("T4 err 13", err_sym, 1);
    chk("T4 fill 13", dut.fill_q, 1);
`ifdef HENC_STATS_EN
    chk("T4 sym_count", sym_count, nmapped);
    chk("T4 bit_count", bit_count, nbits);
`endif

    // T5: backpressure hold
    enc_ready = 1'b0;
    send(9); send(2); send(0);
    wait_valid("T5 valid");
    sym_in = 4'd0; sym_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("T5 hold valid", enc_valid, 1);
      chk("T5 hold word", enc_word, peek_word());
      chk("T5 hold bits", enc_bits, 10);
      chk("T5 hold ready", sym_ready, 0);
      cyc();
    end
    sym_valid = 1'b0; enc_ready = 1'b1;
    cyc();
    chk("T5 resume", sym_ready, 1);

    // T6: reset mid-word with fill = 7
    send(7); send(0); send(0);
    chk("T6 fill", dut.fill_q, 7);
    #2 rst = 1'b0;
    #1;
    chk("T6 sym_ready", sym_ready, 0);
    chk("T6 enc_valid", enc_valid, 0);
    chk("T6 enc_word", enc_word, 0);
    chk("T6 enc_bits", enc_bits, 0);
    chk("T6 flush_done", flush_done, 0);
    chk("T6 err_sym", err_sym, 0);
    chk("T6 fill clr", dut.fill_q, 0);
    bq.delete(); nmapped = 0; nbits = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    send(9); send(2); send(0); send(0);
    wait_valid("T6 valid");
    chk("T6 word", enc_word, 10'h1D7);
    cyc();

    // Random loopback of 200 mapped symbols
    sent.delete(); stream.delete();
    t = 0;
    while (sent.size() < 200 && t < 6000) begin
      do s = $urandom_range(0, 15); while (s == 11 || s == 13);
      sym_in    = 4'(s);
      sym_valid = ($urandom_range(0, 4) != 0);
      enc_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cyc(); t++;
    end
    sym_valid = 1'b0; enc_ready = 1'b1; flush = 1'b1;
    t = 0;
    while (flush_done !== 1'b1 && t < 100) begin cyc(); t++; end
    flush = 1'b0;
    chk("drain done", flush_done, 1);
    repeat (6) cyc();
    chk("drain empty", bq.size(), 0);
`ifdef HENC_STATS_EN
    chk("rand sym_count", sym_count, nmapped);
    chk("rand bit_count", bit_count, nbits);
`endif

    // Decode the emitted stream and compare with what was sent
    idx = 0;
    while (idx < stream.size()) begin
      found = 0;
      for (int l = 1; l <= 6 && !found; l++) begin
        if (idx + l <= stream.size()) begin
          v = 0;
          for (int j = 0; j < l; j++) v = (v << 1) | int'(stream[idx+j]);
          for (int k = 0; k < 16; k++) begin
            if (!found && tlen[k] == l && tcode[k] == v) begin
              found = 1;
              dec.push_back(k);
              idx += l;
            end
          end
        end
      end
      if (!found) break;
    end
    chk("rt count", dec.size(), 200);
    for (int i = 0; i < dec.size() && i < sent.size(); i++) chk("rt sym", dec[i], sent[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
